// File: rtl/loopback_engine_if.sv
// loopback_engine_if: RX/TX word handshake bundle between the core and the loopback engine
interface loopback_engine_if #(parameter int DATA_W = 32);
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              rx_read;
   logic              tx_valid;
   logic              tx_write;
   logic [DATA_W-1:0] tx_data;
   modport master (output rx_valid, rx_data, tx_valid, input rx_read, tx_write, tx_data);
   modport slave (input rx_valid, rx_data, tx_valid, output rx_read, tx_write, tx_data);
endinterface

// File: rtl/loopback_engine.sv
// loopback_engine: loopback FIFO / pattern generator / pattern checker; LOOPBACK_ENGINE_STATS_EN adds word/error counters
module loopback_engine #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [1:0]               mode,
   loopback_engine_if.slave         bus,
   output logic                     busy,
   output logic                     error,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [31:0]              word_cnt,
   output logic [15:0]              err_cnt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t            r_state, w_next;
   logic [1:0]        r_mode;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr, r_rd;
   logic [AW:0]       r_level;
   logic [DATA_W-1:0] r_seq;
   logic              r_busy, r_error;
   logic              w_lb, w_gen, w_chk, w_full, w_empty;
   logic              w_rx_xfer, w_tx_xfer, w_push, w_pop, w_start, w_mis;
   assign w_lb      = r_mode == 2'd0;
   assign w_gen     = r_mode == 2'd1;
   assign w_chk     = r_mode == 2'd2;
   assign w_full    = r_level == (AW+1)'(DEPTH);
   assign w_empty   = r_level == '0;
   assign w_start   = r_state == IDLE && w_next == RUN;
   assign bus.rx_read  = r_state == RUN && (w_lb ? !w_full : w_chk);
   assign bus.tx_write = w_lb ? (r_state != IDLE && !w_empty) : (w_gen && r_state == RUN);
   assign bus.tx_data  = r_state == IDLE ? '0 : w_lb ? r_mem[r_rd] : w_gen ? r_seq : '0;
   assign w_rx_xfer = bus.rx_read && bus.rx_valid;
   assign w_tx_xfer = bus.tx_write && bus.tx_valid;
   assign w_push    = w_lb && w_rx_xfer;
   assign w_pop     = w_lb && w_tx_xfer;
   assign w_mis     = bus.rx_data != r_seq;
   assign busy       = r_busy;
   assign error      = r_error;
   assign fifo_level = r_level;
   // next state: start on a valid run request, drain once en drops, leave drain when the FIFO is empty
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (en && mode != 2'd3) w_next = RUN;
         RUN:     if (!en) w_next = DRAIN;
         DRAIN:   if (w_empty) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // state register, mode latched only at run start, busy registered from next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_mode  <= 2'd3;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= w_next != IDLE;
         if (w_start) r_mode <= mode;
      end
   end
   // FIFO storage; contents are discarded by resetting the pointers, not the array
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= bus.rx_data;
   end
   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   // shared sequence counter: generator output or checker expectation (always resyncs to rx_data+1)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seq   <= '0;
         r_error <= 1'b0;
      end else if (w_start) begin
         r_seq   <= '0;
         r_error <= 1'b0;
      end else if (w_gen && w_tx_xfer) begin
         r_seq <= r_seq + DATA_W'(1);
      end else if (w_chk && w_rx_xfer) begin
         r_seq <= bus.rx_data + DATA_W'(1);
         if (w_mis) r_error <= 1'b1;
      end
   end
`ifdef LOOPBACK_ENGINE_STATS_EN
   logic [31:0] r_word_cnt;
   logic [15:0] r_err_cnt;
   // transfer and saturating mismatch counters, cleared at run start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word_cnt <= '0;
         r_err_cnt  <= '0;
      end else if (w_start) begin
         r_word_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (w_gen ? w_tx_xfer : w_rx_xfer) r_word_cnt <= r_word_cnt + 32'd1;
         if (w_chk && w_rx_xfer && w_mis && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
   end
   assign word_cnt = r_word_cnt;
   assign err_cnt  = r_err_cnt;
`else
   assign word_cnt = '0;
   assign err_cnt  = '0;
`endif
endmodule

// File: tb/tb_loopback_engine.sv
// tb_loopback_engine: randomized self-checking bench against a queue-based behavioural model
module tb_loopback_engine;
`ifdef LOOPBACK_ENGINE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int DEPTH = 16;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, en8 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [1:0] mode8 = 2'd1;
   logic busy, error, busy8, error8;
   logic [4:0] fifo_level, fifo_level8;
   logic [31:0] word_cnt, word_cnt8;
   logic [15:0] err_cnt, err_cnt8;
   loopback_engine_if #(.DATA_W(32)) b32 ();
   loopback_engine_if #(.DATA_W(8))  b8 ();
   loopback_engine #(.DATA_W(32), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .bus(b32.slave),
      .busy(busy), .error(error), .fifo_level(fifo_level), .word_cnt(word_cnt), .err_cnt(err_cnt));
   loopback_engine #(.DATA_W(8), .DEPTH(DEPTH)) u_dut8 (
      .clk(clk), .rst(rst), .en(en8), .mode(mode8), .bus(b8.slave),
      .busy(busy8), .error(error8), .fifo_level(fifo_level8), .word_cnt(word_cnt8), .err_cnt(err_cnt8));
   always #5 clk = ~clk;
   int n_chk = 0, n_err = 0;
   int m_st = 0, m_mode = 3, m_ec = 0, cyc = 0, first_rx = -1, first_tx = -1, n_tx = 0;
   logic [31:0] q [$];
   logic [31:0] m_seq = '0, m_wc = '0;
   bit m_error = 1'b0, mon_on = 1'b0, mon8 = 1'b0, m8_run = 1'b0, saw_wrap = 1'b0;
   logic [7:0] m8 = '0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   task automatic monitor();
      logic exp_rd, exp_wr, rx_x, tx_x;
      int sz;
      cyc++;
      if (mon_on) begin
         sz = q.size();
         check("busy", busy, 32'(m_st != 0));
         check("level", fifo_level, sz);
         check("error", error, m_error);
         check("word_cnt", word_cnt, STATS ? m_wc : 32'd0);
         check("err_cnt", err_cnt, STATS ? m_ec : 0);
         exp_rd = m_st == 1 && (m_mode == 0 ? sz < DEPTH : m_mode == 2);
         exp_wr = m_mode == 0 ? (m_st != 0 && sz > 0) : (m_mode == 1 && m_st == 1);
         check("rx_read", b32.rx_read, exp_rd);
         check("tx_write", b32.tx_write, exp_wr);
         if (b32.rx_read && b32.rx_valid && first_rx < 0) first_rx = cyc;
         if (b32.tx_write && first_tx < 0) first_tx = cyc;
         if (m_st == 1 && m_mode == 1) check("gen_data", b32.tx_data, m_seq);
         rx_x = exp_rd && b32.rx_valid;
         tx_x = exp_wr && b32.tx_valid;
         if (tx_x) begin
            n_tx++;
            if (m_mode == 1) begin
               m_seq++;
               m_wc++;
            end else if (m_mode == 0 && q.size() > 0) check("lb_data", b32.tx_data, q.pop_front());
         end
         if (rx_x) begin
            m_wc++;
            if (m_mode == 0) q.push_back(b32.rx_data);
            else begin
               if (b32.rx_data !== m_seq) begin
                  m_error = 1'b1;
                  if (m_ec < 65535) m_ec++;
               end
               m_seq = b32.rx_data + 32'd1;
            end
         end
         if (m_st == 0 && en && mode != 2'd3) begin
            m_st = 1;
            m_mode = mode;
            m_seq = '0;
            m_error = 1'b0;
            m_wc = '0;
            m_ec = 0;
         end else if (m_st == 1 && !en) m_st = 2;
         else if (m_st == 2 && sz == 0) m_st = 0;
      end
      if (mon8) begin
         check("g8_write", b8.tx_write, m8_run);
         if (m8_run && b8.tx_valid) begin
            check("g8_data", b8.tx_data, m8);
            if (m8 == 8'hFF) saw_wrap = 1'b1;
            m8++;
         end
         if (en8) m8_run = 1'b1;
      end
   endtask
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && busy; i++) tick();
      check("idle_timeout", busy, 0);
   endtask
   task automatic push_n(input int n);
      b32.tx_valid = 1'b0;
      b32.rx_valid = 1'b0;
      en = 1'b1;
      mode = 2'd0;
      tick();
      for (int i = 0; i < n; i++) begin
         b32.rx_valid = 1'b1;
         b32.rx_data = $urandom;
         tick();
      end
      b32.rx_valid = 1'b0;
      en = 1'b0;
      b32.tx_valid = 1'b1;
      n_tx = 0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end
   initial begin
      int sent;
      logic w;
      logic [31:0] nxt;
      b32.rx_valid = 1'b0;
      b32.rx_data = '0;
      b32.tx_valid = 1'b0;
      b8.rx_valid = 1'b0;
      b8.rx_data = '0;
      b8.tx_valid = 1'b0;
      #1 rst = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_level", fifo_level, 0);
      check("rst_rx_read", b32.rx_read, 0);
      check("rst_tx_write", b32.tx_write, 0);
      check("rst_tx_data", b32.tx_data, 0);
      check("rst_error", error, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      mon_on = 1'b1;
      tick();
      // ordered loopback of 1..32 with a free TX path
      mode = 2'd0;
      en = 1'b1;
      b32.tx_valid = 1'b1;
      b32.rx_valid = 1'b1;
      n_tx = 0;
      sent = 0;
      for (int i = 0; i < 200 && sent < 32; i++) begin
         b32.rx_data = sent + 1;
         w = b32.rx_read;
         tick();
         if (w) sent++;
      end
      b32.rx_valid = 1'b0;
      for (int i = 0; i < 50 && n_tx < 32; i++) tick();
      check("lb_latency", first_tx - first_rx, 1);
      check("lb_tx_count", n_tx, 32);
      check("lb_word_cnt", word_cnt, STATS ? 32 : 0);
      en = 1'b0;
      tick();
      wait_idle(40);
      // backpressure fills the FIFO, a pop while full blocks the push, then refill and drain
      en = 1'b1;
      b32.tx_valid = 1'b0;
      b32.rx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b32.rx_data = $urandom;
         tick();
      end
      check("bp_level", fifo_level, 16);
      check("bp_rx_read", b32.rx_read, 0);
      b32.tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b32.rx_data = $urandom;
         tick();
      end
      b32.tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b32.rx_data = $urandom;
         tick();
      end
      check("bp_refill", fifo_level, 16);
      b32.rx_valid = 1'b0;
      b32.tx_valid = 1'b1;
      en = 1'b0;
      n_tx = 0;
      wait_idle(60);
      check("bp_out_count", n_tx, 16);
      // random loopback traffic; mid-run mode change must be ignored
      en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         b32.rx_valid = $urandom_range(0, 3) != 0;
         b32.tx_valid = $urandom_range(0, 2) != 0;
         b32.rx_data = $urandom;
         if (i == 200) mode = 2'd1;
         tick();
      end
      en = 1'b0;
      b32.rx_valid = 1'b0;
      b32.tx_valid = 1'b1;
      wait_idle(60);
      // generator with tx_valid toggling
      mode = 2'd1;
      en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         b32.tx_valid = i[0];
         b32.rx_valid = $urandom_range(0, 1);
         tick();
      end
      en = 1'b0;
      b32.rx_valid = 1'b0;
      wait_idle(10);
      // checker: 0,1,2,7,8 gives one mismatch then resync
      mode = 2'd2;
      en = 1'b1;
      b32.rx_valid = 1'b0;
      tick();
      foreach (q[i]) check("chk_q_empty", 1, 0);
      for (int k = 0; k < 7; k++) begin
         b32.rx_valid = 1'b1;
         b32.rx_data = k < 3 ? k : k + 4;
         tick();
      end
      b32.rx_valid = 1'b0;
      tick();
      check("chk_error", error, 1);
      check("chk_err_cnt", err_cnt, STATS ? 1 : 0);
      nxt = 32'd11;
      for (int i = 0; i < 120; i++) begin
         b32.rx_valid = $urandom_range(0, 3) != 0;
         b32.rx_data = $urandom_range(0, 9) == 0 ? $urandom : nxt;
         if (b32.rx_valid) nxt = b32.rx_data + 1;
         tick();
      end
      en = 1'b0;
      b32.rx_valid = 1'b0;
      wait_idle(10);
      // drain of 5 queued words
      push_n(5);
      wait_idle(40);
      check("drain_count", n_tx, 5);
      // reset asserted mid-drain takes effect in the same cycle
      push_n(5);
      tick();
      tick();
      mon_on = 1'b0;
      rst = 1'b0;
      #1;
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_rx_read", b32.rx_read, 0);
      check("mid_rst_tx_write", b32.tx_write, 0);
      check("mid_rst_tx_data", b32.tx_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_word_cnt", word_cnt, 0);
      check("mid_rst_err_cnt", err_cnt, 0);
      q.delete();
      m_st = 0;
      m_mode = 3;
      m_seq = '0;
      m_error = 1'b0;
      m_wc = '0;
      m_ec = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      mon_on = 1'b1;
      b32.tx_valid = 1'b0;
      tick();
      // 8-bit generator wraps 0xFF -> 0x00
      mon8 = 1'b1;
      en8 = 1'b1;
      for (int i = 0; i < 600; i++) begin
         b8.tx_valid = i[0];
         tick();
      end
      check("g8_wrapped", saw_wrap, 1);
      mon8 = 1'b0;
      en8 = 1'b0;
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/loopback_engine.md
LOOPBACK_ENGINE -- requirements
Module: loopback_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of rx/tx data words.
REQ-002 SHALL have parameter DEPTH, default 16: loopback FIFO depth in words, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: run request.
REQ-006 SHALL have port mode, input, 2: 0 = loopback, 1 = generator, 2 = checker, 3 = reserved/idle.
REQ-007 SHALL have port rx_valid, input, 1: core RX word available on rx_data (show-ahead).
REQ-008 SHALL have port rx_data, input, DATA_W: core RX word.
REQ-009 SHALL have port rx_read, output, 1: consume RX word; a transfer occurs when rx_read and rx_valid are both high in the same cycle.
REQ-010 SHALL have port tx_valid, input, 1: core TX path can accept a word.
REQ-011 SHALL have port tx_write, output, 1: write tx_data; a transfer occurs when tx_write and tx_valid are both high.
REQ-012 SHALL have port tx_data, output, DATA_W: TX word.
REQ-013 SHALL have port busy, output, 1: state is not IDLE.
REQ-014 SHALL have port error, output, 1: sticky checker mismatch flag.
REQ-015 SHALL have port fifo_level, output, clog2(DEPTH)+1: loopback FIFO occupancy.
REQ-016 SHALL have port word_cnt, output, 32: count of transfers.
REQ-017 SHALL have port err_cnt, output, 16: count of mismatches.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN.
REQ-019 IDLE->RUN SHALL occur when en=1 and mode!=3; on this transition mode is latched into mode_q, error and err_cnt clear, word_cnt clears, and generator/expected counters load 0.
REQ-020 RUN->DRAIN SHALL occur when en=0; DRAIN->IDLE SHALL occur when the FIFO is empty; in generator or checker mode DRAIN lasts exactly 1 cycle.
REQ-021 A mode change during RUN or DRAIN SHALL be ignored until the next IDLE->RUN transition.
REQ-022 Loopback: rx_read SHALL equal RUN and FIFO not full; tx_write SHALL equal (RUN or DRAIN) and FIFO not empty; tx_data SHALL be the FIFO head.
REQ-023 Loopback latency: a word accepted from RX in cycle n SHALL be presentable on tx_data with tx_write in cycle n+1 at the earliest; the FIFO has no combinational bypass.
REQ-024 FIFO full with tx_valid=1 SHALL pop one word; rx_read SHALL be deasserted that cycle, and the push resumes in the next cycle.
REQ-025 FIFO push and pop in the same cycle SHALL leave fifo_level unchanged; pointers SHALL wrap modulo DEPTH; word order SHALL be preserved.
REQ-026 Generator: tx_write SHALL be 1 in RUN; tx_data SHALL be gen_cnt; gen_cnt SHALL increment per TX transfer and wrap at 2^DATA_W; rx_read SHALL be 0.
REQ-027 Checker: rx_read SHALL be 1 in RUN; on each RX transfer, if rx_data != expected then error<=1, err_cnt increments, and expected<=rx_data+1 (resync); otherwise expected<=expected+1.
REQ-028 err_cnt SHALL saturate at 0xFFFF; word_cnt SHALL count RX transfers (loopback, checker) or TX transfers (generator) and SHALL wrap at 2^32.
REQ-029 In IDLE, rx_read and tx_write SHALL be 0.
REQ-030 busy, error, fifo_level, word_cnt and err_cnt SHALL be driven from registers.

Reset
REQ-031 While rst=0, the block SHALL be in IDLE with FIFO pointers at 0, fifo_level=0, rx_read=0, tx_write=0, tx_data=0, busy=0, error=0, word_cnt=0, err_cnt=0, and mode_q=3.
REQ-032 Reset asserted mid-transfer SHALL discard FIFO contents immediately, and no transfer SHALL be signalled in that cycle.

Configuration
REQ-033 With macro LOOPBACK_ENGINE_STATS_EN defined, word_cnt and err_cnt SHALL be implemented as specified.
REQ-034 Without LOOPBACK_ENGINE_STATS_EN, word_cnt and err_cnt SHALL be tied to 0 with no counter registers; error SHALL still function.

Verification
REQ-035 Loopback: mode=0, en=1, push 0x00000001..0x00000020 with tx_valid=1 -> identical sequence on TX, first tx_write one cycle after first RX transfer, word_cnt=32.
REQ-036 Backpressure: mode=0, tx_valid=0, rx_valid=1 -> fifo_level reaches 16 and rx_read=0; then tx_valid=1 -> 16 words output in order.
REQ-037 Generator: mode=1, tx_valid toggling every cycle -> tx_data 0,1,2,... advancing only on accepted writes; with DATA_W=8, 0xFF is followed by 0x00.
REQ-038 Checker: rx stream 0,1,2,7,8 -> error=1, err_cnt=1, and no further error after resync at 7.
REQ-039 Drain and reset: en=0 with 5 words queued -> 5 TX writes in DRAIN, then IDLE; repeat with rst=0 mid-drain -> fifo_level=0 and outputs at reset values in the same cycle.
